spi_burst_ram_slave: RTL and testbench
======================================

// Module: spi_burst_ram_slave
// PURPOSE
//  SPI slave with integrated RAM; next-generation SPI wrapper. Widths and depth are parametrised.
//  Adds burst read/write with optional address auto-increment, and frame-abort detection.
//  Sits between the external SPI master pins and on-chip storage; all logic is in the clk domain.
// PARAMETERS
//  ADDR_SIZE  8    address width; MEM_DEPTH <= 2**ADDR_SIZE
//  DATA_SIZE  8    word width, shifted MSB-first
//  MEM_DEPTH  256  number of words
//  AUTO_INC   1    1: address +1 after each word in burst (wraps MEM_DEPTH-1 -> 0); 0: address held
// PORTS
//  clk     in  1  clock, all sampling on posedge
//  rst_n   in  1  asynchronous, active-low reset
//  SS_n    in  1  slave select, active-low
//  MOSI    in  1  serial in, sampled on posedge only when SS_n=0
//  MISO    out 1  serial out; 0 except while shifting read data
//  busy    out 1  1 whenever FSM != IDLE
//  abort   out 1  1-cycle pulse: frame ended (SS_n=1) mid-command/address/partial write word
// BEHAVIOUR
//  Reset: MISO=0, busy=0, abort=0, wr_addr=rd_addr=0, FSM=IDLE, shift/bit counters=0.
//   RAM contents are not reset.
//  Cycle numbering: P0 is the first posedge with SS_n=0 in IDLE. FSM goes to CMD; MOSI is ignored at P0.
//  P1, P2: opcode bits op[1], op[0]. 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_WAIT.
//  WR_ADDR / RD_ADDR: ADDR_SIZE bits at P3..P2+ADDR_SIZE.
//   wr_addr/rd_addr is updated at the posedge after the last bit; FSM then goes to DRAIN.
//  DRAIN: MOSI ignored until SS_n=1.
//  WR_DATA: words of DATA_SIZE bits back-to-back from P3.
//   Each completed word: mem[wr_addr] written at the next posedge; wr_addr += AUTO_INC on the same edge.
//   The commit happens even if SS_n=1 at that edge.
//  RD_WAIT: P3 registered RAM read of mem[rd_addr]. P4 shift register loaded; MISO = d[DATA_SIZE-1].
//   P4+i: MISO = d[DATA_SIZE-1-i]. rd_addr += AUTO_INC at every load.
//  RD_DATA: the next word is prefetched. MISO at P4+DATA_SIZE = MSB of next word (seamless burst).
//  Address >= MEM_DEPTH: writes dropped, reads return 0; increment still wraps at MEM_DEPTH-1 -> 0.
//  SS_n sampled 1 in any non-IDLE state: FSM -> IDLE on that edge; MISO=0 from that edge.
//   Partial word or partial address is discarded; wr_addr/rd_addr keep their last values.
//  abort=1 on that edge iff the state was CMD, WR_ADDR, RD_ADDR, or WR_DATA with bit count != 0.
//   Never asserted from RD_WAIT, RD_DATA, DRAIN, or IDLE.
//  rst_n low mid-frame: immediate (async) return to reset values; an in-flight write is not committed.
//  Read-after-write to the same address inside one cycle is not a case: read and write frames are disjoint.
// STRUCTURE
//  spi_burst_pkg: state_e {IDLE,CMD,WR_ADDR,RD_ADDR,WR_DATA,RD_WAIT,RD_DATA,DRAIN};
//   opcode localparams OP_WA=2'b00, OP_WD=2'b01, OP_RA=2'b10, OP_RD=2'b11.
//  Sub-module spi_burst_ram: 1 write port + 1 registered read port, MEM_DEPTH x DATA_SIZE, no reset on array.
//  Top holds FSM, bit counter ($clog2(max(ADDR,DATA)+1)), shift-in/shift-out regs, address pointers.
// TESTING
//  1 rst_n=0 with random SS_n/MOSI for 100 cycles -> MISO=0, busy=0, abort=0 every cycle.
//  2 WA 0x10; WD burst A5,3C,F0 (AUTO_INC=1); RA 0x10; RD 24 bits -> MISO = A53CF0 MSB-first, no gap.
//  3 WA 0xFF, WD 11,22 -> mem[0xFF]=11, mem[0x00]=22 (wrap); RA 0xFF, RD 16 bits -> 1122.
//  4 WA 0x20; WD 0x77; then WD frame ends after 5 bits -> abort pulse 1 cycle; mem[0x21] unchanged.
//  5 rst_n pulled low at bit 4 of a WD word -> no RAM write; MISO=0; next RA 0x00/RD returns prior data.
//  6 AUTO_INC=0 build: WD burst 01,02,03 at 0x40 -> mem[0x40]=03; RD 16 bits -> 0303.

Source files
------------

// File: rtl/spi_burst_pkg.sv
// Shared types for the SPI burst RAM slave: FSM state encoding, opcodes and a
// small elaboration-time helper.
package spi_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_ADDR,
    RD_ADDR,
    WR_DATA,
    RD_WAIT,
    RD_DATA,
    DRAIN
  } state_e;

  localparam logic [1:0] OP_WA = 2'b00;
  localparam logic [1:0] OP_WD = 2'b01;
  localparam logic [1:0] OP_RA = 2'b10;
  localparam logic [1:0] OP_RD = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_burst_ram.sv
// Single write port, single registered read port storage. Addresses at or
// beyond MEM_DEPTH drop writes and read back as zero.
module spi_burst_ram
  import spi_burst_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [ADDR_SIZE-1:0] i_wr_addr,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  input  logic [ADDR_SIZE-1:0] i_rd_addr,
  output logic [DATA_SIZE-1:0] o_rd_data
);

  localparam int MEM_AW = max_int(1, $clog2(MEM_DEPTH));

  logic [DATA_SIZE-1:0] r_mem [MEM_DEPTH];
  logic [DATA_SIZE-1:0] r_rd_data;
  logic                 w_wr_ok;
  logic                 w_rd_ok;

  assign w_wr_ok = (32'(i_wr_addr) < 32'(MEM_DEPTH));
  assign w_rd_ok = (32'(i_rd_addr) < 32'(MEM_DEPTH));

  // NOTE: the array and its read register have no reset; storage keeps its
  // contents across rst_n and only the control logic around it is cleared.
  always_ff @(posedge clk) begin
    if (i_we && w_wr_ok) begin
      r_mem[i_wr_addr[MEM_AW-1:0]] <= i_wr_data;
    end
    r_rd_data <= w_rd_ok ? r_mem[i_rd_addr[MEM_AW-1:0]] : '0;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spi_burst_ram_slave.sv
// SPI slave front end with burst read/write into local RAM, optional address
// auto-increment and detection of frames that end mid-transfer.
module spi_burst_ram_slave
  import spi_burst_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int MEM_DEPTH = 256,
  parameter bit AUTO_INC  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic abort
);

  localparam int SH_W  = max_int(ADDR_SIZE, DATA_SIZE);
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_SIZE - 1);
  localparam logic [CNT_W-1:0] DATA_FULL = CNT_W'(DATA_SIZE);

  state_e               r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [SH_W-1:0]      r_shift_in;
  logic [DATA_SIZE-1:0] r_shift_out;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wr_pend;
  logic [DATA_SIZE-1:0] r_wr_data;
  logic                 r_miso;
  logic                 r_abort;

  logic [SH_W-1:0]      w_shift_next;
  logic [DATA_SIZE-1:0] w_rd_data;
  logic                 w_addr_done;
  logic                 w_abort_cond;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    if (!AUTO_INC) return a;
    if (32'(a) == 32'(MEM_DEPTH - 1)) return '0;
    return a + ADDR_SIZE'(1);
  endfunction

  assign w_shift_next = {r_shift_in[SH_W-2:0], MOSI};

  // A complete address is committed on the edge after its last bit, even when
  // that edge also closes the frame; only a partial address counts as aborted.
  assign w_addr_done = ((r_state == WR_ADDR) || (r_state == RD_ADDR)) &&
                       (r_bit_cnt == ADDR_LAST);

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block can leave it holding a value (no latch).
  always_comb begin
    w_abort_cond = 1'b0;
    case (r_state)
      CMD:              w_abort_cond = 1'b1;
      WR_ADDR, RD_ADDR: w_abort_cond = !w_addr_done;
      WR_DATA:          w_abort_cond = (r_bit_cnt != '0);
      default:          w_abort_cond = 1'b0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_wr_pend   <= 1'b0;
      r_wr_data   <= '0;
      r_miso      <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_abort   <= 1'b0;
      r_wr_pend <= 1'b0;

      // The RAM writes the pending word on this same edge.
      if (r_wr_pend) begin
        r_wr_addr <= next_addr(r_wr_addr);
      end

      if (w_addr_done) begin
        if (r_state == WR_ADDR) r_wr_addr <= r_shift_in[ADDR_SIZE-1:0];
        else                    r_rd_addr <= r_shift_in[ADDR_SIZE-1:0];
      end

      if ((r_state != IDLE) && SS_n) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_abort   <= w_abort_cond;
      end else begin
        case (r_state)
          IDLE: begin
            if (!SS_n) begin
              r_state   <= CMD;
              r_bit_cnt <= '0;
            end
          end

          CMD: begin
            r_shift_in <= w_shift_next;
            if (r_bit_cnt == CNT_ONE) begin
              r_bit_cnt <= '0;
              case (w_shift_next[1:0])
                OP_WA:   r_state <= WR_ADDR;
                OP_WD:   r_state <= WR_DATA;
                OP_RA:   r_state <= RD_ADDR;
                default: r_state <= RD_WAIT;
              endcase
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
          end

          WR_ADDR, RD_ADDR: begin
            if (w_addr_done) begin
              r_state <= DRAIN;
            end else begin
              r_shift_in <= w_shift_next;
              r_bit_cnt  <= r_bit_cnt + CNT_ONE;
            end
          end

          WR_DATA: begin
            r_shift_in <= w_shift_next;
            if (r_bit_cnt == DATA_LAST) begin
              r_bit_cnt <= '0;
              r_wr_pend <= 1'b1;
              r_wr_data <= w_shift_next[DATA_SIZE-1:0];
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
          end

          // First edge lets the registered RAM read settle; second edge loads.
          RD_WAIT: begin
            if (r_bit_cnt == '0) begin
              r_bit_cnt <= CNT_ONE;
            end else begin
              r_state     <= RD_DATA;
              r_miso      <= w_rd_data[DATA_SIZE-1];
              r_shift_out <= {w_rd_data[DATA_SIZE-2:0], 1'b0};
              r_rd_addr   <= next_addr(r_rd_addr);
              r_bit_cnt   <= CNT_ONE;
            end
          end

          // The RAM has already fetched the next word, so bursts run gap-free.
          RD_DATA: begin
            if (r_bit_cnt == DATA_FULL) begin
              r_miso      <= w_rd_data[DATA_SIZE-1];
              r_shift_out <= {w_rd_data[DATA_SIZE-2:0], 1'b0};
              r_rd_addr   <= next_addr(r_rd_addr);
              r_bit_cnt   <= CNT_ONE;
            end else begin
              r_miso      <= r_shift_out[DATA_SIZE-1];
              r_shift_out <= {r_shift_out[DATA_SIZE-2:0], 1'b0};
              r_bit_cnt   <= r_bit_cnt + CNT_ONE;
            end
          end

          DRAIN:   r_state <= DRAIN;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  spi_burst_ram #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_ram (
    .clk      (clk),
    .i_we     (r_wr_pend),
    .i_wr_addr(r_wr_addr),
    .i_wr_data(r_wr_data),
    .i_rd_addr(r_rd_addr),
    .o_rd_data(w_rd_data)
  );

  assign MISO  = r_miso;
  assign abort = r_abort;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_spi_burst_ram_slave.sv
// Directed and randomized frame-level bench for spi_burst_ram_slave; instance 0
// auto-increments over 256 words, instance 1 holds its address over 128 words.
module tb_spi_burst_ram_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] ss_n = 2'b11;
  logic       mosi = 1'b0;
  logic [1:0] miso;
  logic [1:0] busy;
  logic [1:0] abort;

  int checks = 0;
  int errors = 0;
  int abort_seen [2] = '{0, 0};
  int abort_exp  [2] = '{0, 0};

  // Reference model: word storage and address pointers per instance.
  logic [7:0] mem_m [2][256];
  int         wa_m  [2] = '{0, 0};
  int         ra_m  [2] = '{0, 0};

  always #5 clk = ~clk;

  spi_burst_ram_slave #(
    .ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(256), .AUTO_INC(1'b1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi),
    .MISO(miso[0]), .busy(busy[0]), .abort(abort[0])
  );

  spi_burst_ram_slave #(
    .ADDR_SIZE(8), .DATA_SIZE(8), .MEM_DEPTH(128), .AUTO_INC(1'b0)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi),
    .MISO(miso[1]), .busy(busy[1]), .abort(abort[1])
  );

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) if (abort[k]) abort_seen[k]++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int depth_of(input int d);
    return (d == 0) ? 256 : 128;
  endfunction

  function automatic int next_a(input int d, input int a);
    if (d == 1) return a;
    if (a == depth_of(d) - 1) return 0;
    return (a + 1) % 256;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      mosi = 1'($urandom);
    end
  endtask

  task automatic start_frame(input int d);
    @(negedge clk);
    ss_n[d] = 1'b0;
    mosi    = 1'($urandom);
  endtask

  task automatic end_frame(input int d);
    @(negedge clk);
    ss_n[d] = 1'b1;
    mosi    = 1'($urandom);
  endtask

  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      mosi = v[i];
    end
  endtask

  task automatic addr_frame(input int d, input bit is_rd, input int a);
    start_frame(d);
    shift_bits(is_rd ? 32'd2 : 32'd0, 2);
    shift_bits(32'(a), 8);
    idle_cycles(1 + $urandom_range(0, 3));
    end_frame(d);
    if (is_rd) ra_m[d] = a;
    else       wa_m[d] = a;
  endtask

  // Words are packed first-word-highest in data.
  task automatic write_frame(input int d, input int n, input logic [31:0] data);
    logic [7:0] w;
    start_frame(d);
    shift_bits(32'd1, 2);
    for (int i = 0; i < n; i++) begin
      w = data[8*(n-1-i) +: 8];
      shift_bits(32'(w), 8);
      if (wa_m[d] < depth_of(d)) mem_m[d][wa_m[d]] = w;
      wa_m[d] = next_a(d, wa_m[d]);
    end
    end_frame(d);
  endtask

  task automatic read_frame(input int d, input int n, input string tag);
    logic [31:0] exp_v = '0;
    logic [31:0] got_v = '0;
    for (int i = 0; i < n; i++) begin
      exp_v = (exp_v << 8) | ((ra_m[d] < depth_of(d)) ? 32'(mem_m[d][ra_m[d]]) : 32'd0);
      ra_m[d] = next_a(d, ra_m[d]);
    end
    start_frame(d);
    shift_bits(32'd3, 2);
    @(negedge clk);
    mosi = 1'($urandom);
    check({tag, "_busy"}, 32'(busy[d]), 32'd1);
    @(negedge clk);
    mosi = 1'($urandom);
    for (int i = 0; i < 8 * n; i++) begin
      @(negedge clk);
      got_v = {got_v[30:0], miso[d]};
      mosi  = 1'($urandom);
      if (i == 8 * n - 1) ss_n[d] = 1'b1;
    end
    check(tag, got_v, exp_v);
    @(negedge clk);
    check({tag, "_idle"}, 32'({miso[d], busy[d]}), 32'd0);
  endtask

  task automatic expect_abort_pulse(input int d, input string tag);
    abort_exp[d]++;
    @(negedge clk);
    check({tag, "_hi"}, 32'(abort[d]), 32'd1);
    @(negedge clk);
    check({tag, "_lo"}, 32'(abort[d]), 32'd0);
  endtask

  initial begin
    logic [31:0] rdata;
    int          ra;
    int          rn;

    // Reset held with random pin activity.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({miso, busy, abort}), 32'd0);
      ss_n = 2'($urandom);
      mosi = 1'($urandom);
    end
    @(negedge clk);
    ss_n  = 2'b11;
    rst_n = 1'b1;
    idle_cycles(2);

    // Burst write then seamless burst read.
    addr_frame(0, 1'b0, 8'h10);
    write_frame(0, 3, 32'h00A53CF0);
    addr_frame(0, 1'b1, 8'h10);
    read_frame(0, 3, "burst_a53cf0");

    // Address wrap from the top of memory.
    addr_frame(0, 1'b0, 8'hFF);
    write_frame(0, 2, 32'h00001122);
    addr_frame(0, 1'b1, 8'hFF);
    read_frame(0, 2, "wrap_1122");

    // Partial word after a complete one: pulse, no commit.
    addr_frame(0, 1'b0, 8'h21);
    write_frame(0, 1, 32'h000000C3);
    addr_frame(0, 1'b0, 8'h20);
    write_frame(0, 1, 32'h00000077);
    start_frame(0);
    shift_bits(32'd1, 2);
    shift_bits($urandom, 5);
    end_frame(0);
    expect_abort_pulse(0, "abort_wd5");
    addr_frame(0, 1'b1, 8'h20);
    read_frame(0, 2, "after_abort");

    // Frame dropped inside the command, then inside an address.
    start_frame(0);
    shift_bits(32'd1, 1);
    end_frame(0);
    expect_abort_pulse(0, "abort_cmd");
    start_frame(0);
    shift_bits(32'd2, 2);
    shift_bits($urandom, 3);
    end_frame(0);
    expect_abort_pulse(0, "abort_ra");
    read_frame(0, 1, "ra_kept");

    // Reset mid-word and reset with a completed word awaiting commit.
    addr_frame(0, 1'b0, 8'h00);
    start_frame(0);
    shift_bits(32'd1, 2);
    shift_bits(32'hA, 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_mid_outputs", 32'({miso[0], busy[0], abort[0]}), 32'd0);
    ss_n = 2'b11;
    idle_cycles(2);
    rst_n = 1'b1;
    start_frame(0);
    shift_bits(32'd1, 2);
    shift_bits(32'hEE, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst_pend_outputs", 32'({miso[0], busy[0], abort[0]}), 32'd0);
    ss_n = 2'b11;
    idle_cycles(2);
    rst_n = 1'b1;
    wa_m = '{0, 0};
    ra_m = '{0, 0};
    read_frame(0, 1, "rst_rd_addr0");
    addr_frame(0, 1'b1, 8'h00);
    read_frame(0, 1, "rst_no_commit");

    // Address-hold build and out-of-range access.
    addr_frame(1, 1'b0, 8'h40);
    write_frame(1, 3, 32'h00010203);
    addr_frame(1, 1'b1, 8'h40);
    read_frame(1, 2, "hold_0303");
    addr_frame(1, 1'b0, 8'h90);
    write_frame(1, 1, 32'h00000055);
    addr_frame(1, 1'b1, 8'h90);
    read_frame(1, 1, "oob_read_zero");

    // Randomized bursts against the model.
    for (int r = 0; r < 6; r++) begin
      ra    = $urandom_range(0, 255);
      rn    = $urandom_range(1, 4);
      rdata = $urandom;
      addr_frame(0, 1'b0, ra);
      write_frame(0, rn, rdata);
      addr_frame(0, 1'b1, ra);
      read_frame(0, rn, "rand_burst");
    end

    idle_cycles(2);
    check("abort_count0", 32'(abort_seen[0]), 32'(abort_exp[0]));
    check("abort_count1", 32'(abort_seen[1]), 32'(abort_exp[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
